// File: rtl/rrc_pkg.sv
// Shared types and constants for the rrc ReRAM controller and its bank sequencer.
package rrc_pkg;

  typedef enum logic [1:0] {
    RR_READ  = 2'd0,
    RR_SET   = 2'd1,
    RR_RESET = 2'd2,
    RR_RSVD  = 2'd3
  } rr_op_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    WAIT,
    RESP
  } rr_seq_state_e;

  localparam int unsigned RR_NAP_IDLE = 256;
  localparam int unsigned RR_NAP_WAKE = 4;

  function automatic int unsigned rr_max3(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rram_seq_timer.sv
// Loadable down-counter used for every sequencer phase; saturates at zero.
module rram_seq_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rram_bank_seq.sv
// Multi-bank ReRAM access sequencer: one request at a time, SETUP/PULSE/WAIT/RESP timing.
// Optional per-bank nap with wake-up delay is enabled by defining RRAM_SEQ_NAP_EN.
module rram_bank_seq
  import rrc_pkg::*;
#(
  parameter int unsigned NBANK   = 2,
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 6,
  parameter int unsigned DW      = 144,
  parameter int unsigned T_SETUP = 3,
  parameter int unsigned T_PULSE = 8,
  parameter int unsigned T_RDTO  = 64,
  localparam int unsigned BW     = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [BW-1:0]       req_bank,
  input  logic [XW-1:0]       req_xadr,
  input  logic [YW-1:0]       req_yadr,
  input  logic [DW-1:0]       req_din,
  output logic                rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic [NBANK-1:0]    mac_ce,
  output logic [NBANK-1:0]    mac_xe,
  output logic [NBANK-1:0]    mac_ye,
  output logic [NBANK-1:0]    mac_ae,
  output logic [NBANK-1:0]    mac_read,
  output logic [NBANK-1:0]    mac_set,
  output logic [NBANK-1:0]    mac_reset,
  output logic [XW-1:0]       mac_xadr,
  output logic [YW-1:0]       mac_yadr,
  output logic [DW-1:0]       mac_din,
  input  logic [NBANK-1:0]    mac_rdone,
  input  logic [NBANK*DW-1:0] mac_dout,
  output logic [NBANK-1:0]    mac_nap
);

  localparam int unsigned TMAX = rr_max3(T_SETUP + RR_NAP_WAKE, T_PULSE, T_RDTO);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  rr_seq_state_e state, state_next;
  rr_op_e        op_q;
  logic          err_q;
  logic          rsp_err_q;
  logic [NBANK-1:0] sel_q;
  logic [DW-1:0] data_q;
  logic [XW-1:0] xadr_q;
  logic [YW-1:0] yadr_q;
  logic [DW-1:0] din_q;

  logic          accept;
  logic          req_bad;
  logic [NBANK-1:0] req_sel;
  logic          wake;
  logic          rdone_hit;
  logic [DW-1:0] dout_sel;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_zero;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign req_bad   = (rr_op_e'(req_op) == RR_RSVD) || (32'(req_bank) >= NBANK);

  // One-hot bank selects; an illegal request selects nothing so no pin can move.
  always_comb begin
    req_sel  = '0;
    dout_sel = '0;
    for (int unsigned b = 0; b < NBANK; b++) begin
      req_sel[b] = !req_bad && (32'(req_bank) == b);
      if (sel_q[b]) dout_sel = dout_sel | mac_dout[b*DW +: DW];
    end
  end

  assign rdone_hit = |(mac_rdone & sel_q);

  always_comb begin
    state_next = state;
    tmr_value  = '0;
    mac_ce     = '0;
    mac_xe     = '0;
    mac_ye     = '0;
    mac_ae     = '0;
    mac_read   = '0;
    mac_set    = '0;
    mac_reset  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETUP;
          tmr_value  = TW'(T_SETUP - 1) + (wake ? TW'(RR_NAP_WAKE) : '0);
        end
      end
      SETUP: begin
        mac_ce = sel_q;
        mac_xe = sel_q;
        mac_ye = sel_q;
        // Illegal requests spend one inert SETUP cycle, then report the error.
        if (err_q) begin
          state_next = RESP;
        end else if (tmr_zero) begin
          state_next = PULSE;
          tmr_value  = (op_q == RR_READ) ? '0 : TW'(T_PULSE - 1);
        end
      end
      PULSE: begin
        mac_ce = sel_q;
        mac_xe = sel_q;
        mac_ye = sel_q;
        case (op_q)
          RR_READ: begin
            mac_read = sel_q;
            mac_ae   = sel_q;
          end
          RR_SET:   mac_set   = sel_q;
          RR_RESET: mac_reset = sel_q;
          default:  ;
        endcase
        if (tmr_zero) begin
          state_next = WAIT;
          tmr_value  = TW'(T_RDTO - 1);
        end
      end
      WAIT: begin
        mac_ce = sel_q;
        mac_xe = sel_q;
        mac_ye = sel_q;
        if (op_q == RR_READ) mac_read = sel_q;
        if (rdone_hit || tmr_zero) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign tmr_load = (state_next != state);

  rram_seq_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= RR_READ;
      err_q     <= 1'b0;
      rsp_err_q <= 1'b0;
      sel_q     <= '0;
      data_q    <= '0;
      xadr_q    <= '0;
      yadr_q    <= '0;
      din_q     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q      <= rr_op_e'(req_op);
        err_q     <= req_bad;
        rsp_err_q <= req_bad;
        sel_q     <= req_sel;
        data_q    <= '0;
        if (!req_bad) begin
          xadr_q <= req_xadr;
          yadr_q <= req_yadr;
          din_q  <= req_din;
        end
      end
      if (state == WAIT) begin
        if (rdone_hit) begin
          if (op_q == RR_READ) data_q <= dout_sel;
        end else if (tmr_zero) begin
          rsp_err_q <= 1'b1;
        end
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && rsp_err_q;
  assign rsp_data  = rsp_valid ? data_q : '0;
  assign mac_xadr  = xadr_q;
  assign mac_yadr  = yadr_q;
  assign mac_din   = din_q;

`ifdef RRAM_SEQ_NAP_EN
  logic [NBANK-1:0] nap_q;
  logic [NBANK-1:0] busy;
  logic [8:0]       idle_cnt [NBANK];

  // A bank is busy from its accept until the end of RESP; idle counting restarts afterwards.
  assign busy = (accept ? req_sel : '0) | ((state != IDLE) ? sel_q : '0);
  assign wake = accept && |(req_sel & nap_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      nap_q <= '0;
      for (int unsigned b = 0; b < NBANK; b++) idle_cnt[b] <= '0;
    end else begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        if (busy[b]) begin
          idle_cnt[b] <= '0;
          nap_q[b]    <= 1'b0;
        end else if (idle_cnt[b] != 9'(RR_NAP_IDLE)) begin
          idle_cnt[b] <= idle_cnt[b] + 9'd1;
          if (idle_cnt[b] == 9'(RR_NAP_IDLE - 1)) nap_q[b] <= 1'b1;
        end
      end
    end
  end

  assign mac_nap = nap_q;
`else
  assign wake    = 1'b0;
  assign mac_nap = '0;
`endif

endmodule

// File: tb/tb_rram_bank_seq.sv
// Directed self-checking bench for rram_bank_seq (NBANK=2, default timing parameters).
module tb_rram_bank_seq;

  localparam int unsigned NBANK   = 2;
  localparam int unsigned XW      = 10;
  localparam int unsigned YW      = 6;
  localparam int unsigned DW      = 144;
  localparam int unsigned T_SETUP = 3;
  localparam int unsigned T_PULSE = 8;
  localparam int unsigned T_RDTO  = 64;

  logic                clk;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [0:0]          req_bank;
  logic [XW-1:0]       req_xadr;
  logic [YW-1:0]       req_yadr;
  logic [DW-1:0]       req_din;
  logic                rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic                rsp_err;
  logic [NBANK-1:0]    mac_ce, mac_xe, mac_ye, mac_ae, mac_read, mac_set, mac_reset;
  logic [XW-1:0]       mac_xadr;
  logic [YW-1:0]       mac_yadr;
  logic [DW-1:0]       mac_din;
  logic [NBANK-1:0]    mac_rdone;
  logic [NBANK*DW-1:0] mac_dout;
  logic [NBANK-1:0]    mac_nap;

  logic                rdone_en;
  logic [NBANK-1:0]    rdone_force;
  logic [DW-1:0]       pat0, pat1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  rram_bank_seq #(
    .NBANK(NBANK), .XW(XW), .YW(YW), .DW(DW),
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_RDTO(T_RDTO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_bank(req_bank),
    .req_xadr(req_xadr), .req_yadr(req_yadr), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mac_ce(mac_ce), .mac_xe(mac_xe), .mac_ye(mac_ye), .mac_ae(mac_ae),
    .mac_read(mac_read), .mac_set(mac_set), .mac_reset(mac_reset),
    .mac_xadr(mac_xadr), .mac_yadr(mac_yadr), .mac_din(mac_din),
    .mac_rdone(mac_rdone), .mac_dout(mac_dout), .mac_nap(mac_nap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro stand-in: the selected bank reports done as soon as it is enabled.
  assign mac_rdone = rdone_force | (rdone_en ? mac_ce : '0);
  assign mac_dout  = {pat1, pat0};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [0:0] bank,
                        input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [DW-1:0] din,
                        output int lat, output logic [DW-1:0] data, output logic err,
                        output int strobe_cnt, output logic [NBANK-1:0] pins_seen,
                        output logic [XW-1:0] xs, output logic [YW-1:0] ys,
                        output logic [DW-1:0] dins);
    bit got;
    bit capt;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_bank  = bank;
    req_xadr  = x;
    req_yadr  = y;
    req_din   = din;
    check({tag, "_ready_pre"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid  = 1'b0;
    lat        = 0;
    data       = '0;
    err        = 1'b0;
    strobe_cnt = 0;
    pins_seen  = '0;
    xs         = '0;
    ys         = '0;
    dins       = '0;
    got        = 0;
    capt       = 0;
    for (int c = 1; c <= 200 && !got; c++) begin
      if (c > 1) @(negedge clk);
      pins_seen |= mac_ce | mac_xe | mac_ye | mac_ae | mac_read | mac_set | mac_reset;
      if (mac_set[bank] || mac_reset[bank]) strobe_cnt++;
      if (mac_ce[bank] && !capt) begin
        capt = 1;
        xs   = mac_xadr;
        ys   = mac_yadr;
        dins = mac_din;
      end
      if (rsp_valid) begin
        got  = 1;
        lat  = c;
        data = rsp_data;
        err  = rsp_err;
      end
    end
    if (!got) check({tag, "_no_response"}, 1'b0, 1'b1);
    @(negedge clk);
    check({tag, "_ready_post"}, req_ready, 1'b1);
    check({tag, "_rsp_one_cycle"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               lat, scnt;
    logic [DW-1:0]    data, dins, ones;
    logic             err;
    logic [NBANK-1:0] pins;
    logic [XW-1:0]    xs;
    logic [YW-1:0]    ys;
    bit               seen;

    pat0        = {9{16'h1234}};
    pat1        = {9{16'hABCD}};
    ones        = '1;
    rdone_en    = 1'b1;
    rdone_force = '0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_op      = 2'd0;
    req_bank    = 1'b0;
    req_xadr    = '0;
    req_yadr    = '0;
    req_din     = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_pins", {mac_ce, mac_xe, mac_ye, mac_ae, mac_read, mac_set, mac_reset}, '0);
    check("rst_bus", {mac_xadr, mac_yadr, mac_din}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("first_ready", req_ready, 1'b1);

    // READ bank1, done on first WAIT cycle
    run_op("rd1", 2'd0, 1'b1, 10'h155, 6'h2A, '0, lat, data, err, scnt, pins, xs, ys, dins);
    check("rd1_latency", lat, 6);
    check("rd1_data", data, pat1);
    check("rd1_err", err, 1'b0);
    check("rd1_bank0_quiet", pins[0], 1'b0);
    check("rd1_xadr", xs, 10'h155);
    check("rd1_yadr", ys, 6'h2A);

    // SET bank0, all-ones mask
    run_op("set0", 2'd1, 1'b0, 10'h0F0, 6'h11, ones, lat, data, err, scnt, pins, xs, ys, dins);
    check("set0_latency", lat, 13);
    check("set0_pulse_width", scnt, 8);
    check("set0_err", err, 1'b0);
    check("set0_data", data, '0);
    check("set0_din", dins, ones);
    check("set0_bank1_quiet", pins[1], 1'b0);

    // READ bank1 timing out; the other bank's rdone must be ignored
    rdone_en    = 1'b0;
    rdone_force = 2'b01;
    run_op("rdto", 2'd0, 1'b1, 10'h0AA, 6'h05, '0, lat, data, err, scnt, pins, xs, ys, dins);
    check("rdto_latency", lat, T_SETUP + 1 + T_RDTO + 1);
    check("rdto_err", err, 1'b1);
    check("rdto_data", data, '0);
    rdone_en    = 1'b1;
    rdone_force = '0;

    // Reserved op: error response, no pin or bus activity
    run_op("ill", 2'd3, 1'b0, 10'h3FF, 6'h3F, ones, lat, data, err, scnt, pins, xs, ys, dins);
    check("ill_latency", lat, 2);
    check("ill_err", err, 1'b1);
    check("ill_no_pins", pins, '0);
    check("ill_bus_held", {mac_xadr, mac_yadr}, {10'h0AA, 6'h05});

    // RESET bank1
    run_op("rst1", 2'd2, 1'b1, 10'h001, 6'h01, {9{16'h5555}}, lat, data, err, scnt, pins, xs, ys, dins);
    check("rst1_latency", lat, 13);
    check("rst1_pulse_width", scnt, 8);
    check("rst1_data", data, '0);
    check("rst1_bank0_quiet", pins[0], 1'b0);

    // READ bank0 picks the bank0 slice of mac_dout
    run_op("rd0", 2'd0, 1'b0, 10'h2AA, 6'h15, '0, lat, data, err, scnt, pins, xs, ys, dins);
    check("rd0_latency", lat, 6);
    check("rd0_data", data, pat0);

    // Reset in the middle of a SET pulse
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_bank  = 1'b0;
    req_din   = ones;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c < 20 && !mac_set[0]; c++) @(negedge clk);
    check("midrst_pulse_reached", mac_set[0], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_set_low", mac_set, '0);
    check("midrst_ce_low", mac_ce, '0);
    check("midrst_no_rsp", rsp_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", req_ready, 1'b1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    check("midrst_no_late_rsp", seen, 1'b0);

    repeat (300) @(negedge clk);
`ifdef RRAM_SEQ_NAP_EN
    check("nap_both", mac_nap, 2'b11);
    run_op("nap", 2'd0, 1'b0, 10'h010, 6'h02, '0, lat, data, err, scnt, pins, xs, ys, dins);
    check("nap_wake_latency", lat, 6 + 4);
    check("nap_data", data, pat0);
    check("nap_after", mac_nap, 2'b10);
`else
    check("nap_off", mac_nap, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rram_bank_seq.md
Name: rram_bank_seq

Overview:
Parametrised multi-bank ReRAM access sequencer. It accepts single read/set/reset requests over a valid/ready handshake and drives one of NBANK macro pin sets through timed setup, pulse and done phases. It returns read data or a timeout error. It sits between the rrc controller core and NBANK macro instances; each instance is driven through its per-bank pin group.

Parameters:
NBANK, 2, number of macro banks (1..8)
XW, 10, row address width
YW, 6, column address width
DW, 144, data word width (per macro)
T_SETUP, 3, cycles CE/XE/YE/address held before pulse (>=1)
T_PULSE, 8, SET/RESET pulse width in cycles (>=1)
T_RDTO, 64, max cycles to wait for RDONE before error (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  sequencer can accept request
req_op  in  2  0=READ 1=SET 2=RESET 3=reserved
req_bank  in  $clog2(NBANK) (min 1)  target bank
req_xadr  in  XW  row address
req_yadr  in  YW  column address
req_din  in  DW  write data (SET/RESET bit mask)
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  DW  read data (0 for SET/RESET)
rsp_err  out  1  timeout or illegal op, valid with rsp_valid
mac_ce  out  NBANK  per-bank chip enable
mac_xe, mac_ye  out  NBANK each  per-bank row/column enable
mac_ae  out  NBANK  per-bank read sense enable
mac_read, mac_set, mac_reset  out  NBANK each  per-bank operation strobes
mac_xadr  out  XW  shared row address bus
mac_yadr  out  YW  shared column address bus
mac_din  out  DW  shared data bus
mac_rdone  in  NBANK  per-bank done flag
mac_dout  in  NBANK*DW  per-bank read data, bank b at [b*DW +: DW]
mac_nap  out  NBANK  per-bank nap (optional feature)

Behaviour:
- Reset: all outputs 0 (req_ready=0 during rst); state=IDLE; timer cleared; first cycle after reset req_ready=1.
- Request accepted on req_valid&req_ready; fields captured into registers. req_ready=1 only in IDLE.
- States: IDLE -> SETUP -> PULSE -> WAIT -> RESP -> IDLE.
- IDLE: accept -> SETUP next cycle. op=3 or req_bank>=NBANK: skip to RESP with rsp_err=1; no macro pins toggle.
- SETUP: mac_ce/xe/ye[bank]=1; address/data buses driven from captured regs; lasts T_SETUP cycles.
- PULSE, READ: mac_read and mac_ae[bank]=1 for 1 cycle, then WAIT.
- PULSE, SET/RESET: mac_set or mac_reset[bank]=1 for T_PULSE cycles, then WAIT.
- WAIT: ce/xe/ye held; READ keeps mac_read=1.
  - mac_rdone[bank]=1: capture mac_dout slice (READ only) and go to RESP.
  - Timer reaches T_RDTO with no rdone: RESP with rsp_err=1, rsp_data=0.
- RESP: rsp_valid=1 for exactly 1 cycle; all bank strobes 0; next state IDLE.
- Best-case latency, accept to rsp_valid:
  - READ: T_SETUP+1+1+1 cycles (rdone seen first WAIT cycle).
  - SET/RESET: T_SETUP+T_PULSE+1+1.
- Non-selected banks' pins stay 0 throughout.
- Shared buses hold last value when idle; reset value 0.
- rdone of non-selected banks is ignored.
- rdone already high on entry to WAIT counts as done.
- rst asserted mid-operation: next cycle all strobes 0, state IDLE, no response emitted.
- Timer: single down-counter sized to max(T_SETUP,T_PULSE,T_RDTO), reloaded on each state entry.

Optional Feature:
Macro RRAM_SEQ_NAP_EN.
- Defined: idle counter per bank. A bank unused for 256 consecutive cycles gets mac_nap[b]=1.
- Nap wake-up: an accept to a napping bank clears its nap and inserts 4 extra SETUP cycles before the normal T_SETUP. The idle count restarts after RESP.
- Reset: all nap bits 0, counters 0.
- Undefined: mac_nap tied 0; no wake delay.

Decomposition:
- rrc_pkg gains:
  - rr_op_e enum {RR_READ, RR_SET, RR_RESET, RR_RSVD}.
  - rr_seq_state_e {IDLE, SETUP, PULSE, WAIT, RESP}.
  - localparam RR_NAP_IDLE=256.
  - localparam RR_NAP_WAKE=4.
- Sub-module rram_seq_timer: loadable down-counter with load, value and zero flag. Used for all phase timing.

Test Plan:
- NBANK=2, READ bank1 x=0x155 y=0x2A; drive rdone on 1st WAIT cycle, dout=0xABCD pattern -> rsp_valid at cycle 6 after accept, rsp_data=pattern, rsp_err=0; bank0 pins all 0.
- SET bank0, din=all-ones -> mac_set[0] high exactly 8 cycles, rsp_valid 13 cycles after accept, rsp_err=0.
- READ with rdone never asserted -> rsp_err=1, rsp_data=0 after T_RDTO WAIT cycles; req_ready returns next cycle.
- req_op=3 or req_bank=2 -> rsp_valid 2 cycles after accept, rsp_err=1, no mac_* strobe toggles.
- rst asserted during PULSE of SET -> mac_set=0 next cycle, no rsp_valid, req_ready=1 after rst deasserts.
- RRAM_SEQ_NAP_EN: idle 300 cycles -> mac_nap=2'b11; READ bank0 -> mac_nap[0] clears, latency +4 cycles, mac_nap[1] stays 1.
